// File: rtl/dram_axi_id_remap_pkg.sv
// Shared widths, AXI channel structs and remap-table entry type for the DRAM AXI ID remapper.
package dram_axi_id_remap_pkg;

  localparam int SlvIdWidth   = 6;
  localparam int MstIdWidth   = 2;
  localparam int MaxTxnsPerId = 4;
  localparam int AddrWidth    = 32;
  localparam int DataWidth    = 64;
  localparam int UserWidth    = 1;

  function automatic int calc_cnt_width(input int max_txns);
    return $clog2(max_txns + 1);
  endfunction

  function automatic int calc_num_slots(input int id_width);
    return 1 << id_width;
  endfunction

  localparam int CntWidth = calc_cnt_width(MaxTxnsPerId);
  localparam int NumSlots = calc_num_slots(MstIdWidth);

  typedef struct packed {
    logic                  valid;
    logic [SlvIdWidth-1:0] wide_id;
    logic [CntWidth-1:0]   cnt;
  } slot_t;

  typedef enum logic {LockIdle, LockHold} lock_state_e;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } slv_ax_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } mst_ax_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } w_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [1:0]            resp;
    logic [UserWidth-1:0]  user;
  } slv_b_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [1:0]            resp;
  } mst_b_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [DataWidth-1:0]  data;
    logic [1:0]            resp;
    logic                  last;
    logic [UserWidth-1:0]  user;
  } slv_r_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [DataWidth-1:0]  data;
    logic [1:0]            resp;
    logic                  last;
  } mst_r_t;

  typedef struct packed {
    slv_ax_t aw;
    logic    aw_valid;
    w_t      w;
    logic    w_valid;
    logic    b_ready;
    slv_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } slv_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    slv_b_t b;
    logic   b_valid;
    slv_r_t r;
    logic   r_valid;
  } slv_rsp_t;

  typedef struct packed {
    mst_ax_t aw;
    logic    aw_valid;
    w_t      w;
    logic    w_valid;
    logic    b_ready;
    mst_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } mst_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    mst_b_t b;
    logic   b_valid;
    mst_r_t r;
    logic   r_valid;
  } mst_rsp_t;

endpackage

// File: rtl/dram_axi_id_table.sv
// One direction's ID remap table: slot selection, outstanding counters and the
// IDLE/HOLD lock that keeps the narrow ID stable while the MIG back-pressures.
module dram_axi_id_table
  import dram_axi_id_remap_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid,
  input  logic                  req_ready,
  input  logic [SlvIdWidth-1:0] req_id,
  output logic [MstIdWidth-1:0] slot,
  output logic                  ok,
  input  logic                  rel_valid,
  input  logic [MstIdWidth-1:0] rel_slot,
  output logic [SlvIdWidth-1:0] wide_id
);

  slot_t [NumSlots-1:0]  tbl_q, tbl_d;
  lock_state_e           state_q, state_d;
  logic [MstIdWidth-1:0] sel_q, sel_d, hit_idx, free_idx;
  logic                  hit, has_free, pick_ok, hold, acc;

  always_comb begin
    hit      = 1'b0;
    has_free = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (!hit && tbl_q[i].valid && tbl_q[i].wide_id == req_id) begin
        hit     = 1'b1;
        hit_idx = MstIdWidth'(i);
      end
      if (!has_free && !tbl_q[i].valid) begin
        has_free = 1'b1;
        free_idx = MstIdWidth'(i);
      end
    end
  end

  assign hold    = (state_q == LockHold);
  assign pick_ok = hit ? (tbl_q[hit_idx].cnt < CntWidth'(MaxTxnsPerId)) : has_free;
  assign slot    = hold ? sel_q : (hit ? hit_idx : free_idx);
  // A held request was already granted its slot; nothing else can take it.
  assign ok      = rst_ni & (hold | pick_ok);
  assign acc     = req_valid & ok & req_ready;
  assign wide_id = tbl_q[rel_slot].wide_id;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      LockIdle: if (req_valid && ok && !req_ready) begin
        state_d = LockHold;
        sel_d   = slot;
      end
      LockHold: if (req_valid && req_ready) state_d = LockIdle;
      default:  state_d = LockIdle;
    endcase
  end

  always_comb begin
    logic inc, dec;
    tbl_d = tbl_q;
    inc   = 1'b0;
    dec   = 1'b0;
    for (int i = 0; i < NumSlots; i++) begin
      inc = acc && (slot == MstIdWidth'(i));
      // Responses to an empty slot are protocol errors and leave the table alone.
      dec = rel_valid && (rel_slot == MstIdWidth'(i)) && tbl_q[i].valid;
      if (inc && !dec)      tbl_d[i].cnt = tbl_q[i].cnt + 1'b1;
      else if (!inc && dec) tbl_d[i].cnt = tbl_q[i].cnt - 1'b1;
      if (inc) begin
        tbl_d[i].valid   = 1'b1;
        tbl_d[i].wide_id = req_id;
      end else if (dec && tbl_q[i].cnt == CntWidth'(1) &&
                   !(hold && sel_q == MstIdWidth'(i))) begin
        tbl_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl_q   <= '0;
      state_q <= LockIdle;
      sel_q   <= '0;
    end else begin
      tbl_q   <= tbl_d;
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  rel_on_valid_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rel_valid |-> tbl_q[rel_slot].valid);

endmodule

// File: rtl/dram_axi_id_remap.sv
// AXI4 ID remapper in front of the MIG: wide upstream IDs are compressed into the
// narrow MIG ID space per direction and restored on B/R, with zero added latency.
module dram_axi_id_remap
  import dram_axi_id_remap_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  slv_req_t slv_req_i,
  output slv_rsp_t slv_rsp_o,
  output mst_req_t mst_req_o,
  input  mst_rsp_t mst_rsp_i
);

  logic [MstIdWidth-1:0] aw_slot, ar_slot;
  logic                  aw_ok, ar_ok, b_rel, r_rel;
  logic [SlvIdWidth-1:0] b_wide_id, r_wide_id;

  assign b_rel = mst_rsp_i.b_valid & slv_req_i.b_ready;
  assign r_rel = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;

  dram_axi_id_table i_wr_table (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_valid (slv_req_i.aw_valid),
    .req_ready (mst_rsp_i.aw_ready),
    .req_id    (slv_req_i.aw.id),
    .slot      (aw_slot),
    .ok        (aw_ok),
    .rel_valid (b_rel),
    .rel_slot  (mst_rsp_i.b.id),
    .wide_id   (b_wide_id)
  );

  dram_axi_id_table i_rd_table (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_valid (slv_req_i.ar_valid),
    .req_ready (mst_rsp_i.ar_ready),
    .req_id    (slv_req_i.ar.id),
    .slot      (ar_slot),
    .ok        (ar_ok),
    .rel_valid (r_rel),
    .rel_slot  (mst_rsp_i.r.id),
    .wide_id   (r_wide_id)
  );

  always_comb begin
    mst_req_o.aw       = '{id: aw_slot, addr: slv_req_i.aw.addr, len: slv_req_i.aw.len,
                           size: slv_req_i.aw.size, burst: slv_req_i.aw.burst};
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_ok;
    mst_req_o.w        = slv_req_i.w;
    mst_req_o.w_valid  = slv_req_i.w_valid & rst_ni;
    mst_req_o.b_ready  = slv_req_i.b_ready;
    mst_req_o.ar       = '{id: ar_slot, addr: slv_req_i.ar.addr, len: slv_req_i.ar.len,
                           size: slv_req_i.ar.size, burst: slv_req_i.ar.burst};
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_ok;
    mst_req_o.r_ready  = slv_req_i.r_ready;
  end

  always_comb begin
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_ok;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_ok;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready;
    slv_rsp_o.b        = '{id: b_wide_id, resp: mst_rsp_i.b.resp, user: '0};
    slv_rsp_o.b_valid  = mst_rsp_i.b_valid;
    slv_rsp_o.r        = '{id: r_wide_id, data: mst_rsp_i.r.data, resp: mst_rsp_i.r.resp,
                           last: mst_rsp_i.r.last, user: '0};
    slv_rsp_o.r_valid  = mst_rsp_i.r_valid;
  end

endmodule

// File: tb/tb_dram_axi_id_remap.sv
// Directed bench for dram_axi_id_remap: the bench plays both the upstream master and the MIG.
module tb_dram_axi_id_remap;
  import dram_axi_id_remap_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  slv_req_t slv_req;
  slv_rsp_t slv_rsp;
  mst_req_t mst_req;
  mst_rsp_t mst_rsp;
  int       n_tests = 0;
  int       n_fail  = 0;
  logic [5:0] exp_w [4] = '{6'h01, 6'h05, 6'h03, 6'h04};

  always #5 clk = ~clk;

  dram_axi_id_remap dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .slv_req_i (slv_req),
    .slv_rsp_o (slv_rsp),
    .mst_req_o (mst_req),
    .mst_rsp_i (mst_rsp)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    slv_req = '0;
    mst_rsp = '0;
    rst_n   = 1'b0;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 6'h2A;
    slv_req.w_valid  = 1'b1;
    slv_req.w.data   = 64'h1234;
    mst_rsp.aw_ready = 1'b1;
    mst_rsp.w_ready  = 1'b1;
    tick; tick;
    chk("rst_aw_ready", slv_rsp.aw_ready, 0);
    chk("rst_mst_aw_valid", mst_req.aw_valid, 0);
    chk("rst_mst_w_valid", mst_req.w_valid, 0);

    // basic remap and restore
    rst_n = 1'b1;
    #1;
    chk("aw_2a_id", mst_req.aw.id, 0);
    chk("aw_2a_valid", mst_req.aw_valid, 1);
    chk("aw_2a_ready", slv_rsp.aw_ready, 1);
    chk("w_pass_valid", mst_req.w_valid, 1);
    chk("w_pass_data", mst_req.w.data, 64'h1234);
    tick;
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    slv_req.b_ready  = 1'b1;
    mst_rsp.b_valid  = 1'b1;
    mst_rsp.b.id     = 2'd0;
    mst_rsp.b.resp   = 2'b10;
    #1;
    chk("b_2a_id", slv_rsp.b.id, 6'h2A);
    chk("b_2a_resp", slv_rsp.b.resp, 2'b10);
    chk("b_user_zero", slv_rsp.b.user, 0);
    tick;
    mst_rsp.b_valid = 1'b0;

    // write slot exhaustion
    slv_req.aw_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      slv_req.aw.id = 6'(k);
      #1;
      chk("exh_aw_id", mst_req.aw.id, 64'(k - 1));
      tick;
    end
    slv_req.aw.id = 6'h05;
    #1;
    chk("exh_stall_ready", slv_rsp.aw_ready, 0);
    chk("exh_stall_valid", mst_req.aw_valid, 0);
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id    = 2'd1;
    #1;
    chk("exh_b1_id", slv_rsp.b.id, 6'h02);
    chk("exh_stall_same_cycle", slv_rsp.aw_ready, 0);
    tick;
    mst_rsp.b_valid = 1'b0;
    #1;
    chk("exh_05_ready", slv_rsp.aw_ready, 1);
    chk("exh_05_id", mst_req.aw.id, 1);
    tick;
    slv_req.aw_valid = 1'b0;
    mst_rsp.b_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mst_rsp.b.id = 2'(k);
      #1;
      chk("exh_drain_b_id", slv_rsp.b.id, exp_w[k]);
      tick;
    end
    mst_rsp.b_valid = 1'b0;

    // same-ID reuse on reads
    mst_rsp.ar_ready = 1'b1;
    slv_req.r_ready  = 1'b1;
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 6'h10;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("reuse_ar_id", mst_req.ar.id, 0);
      tick;
    end
    #1;
    chk("reuse_stall", slv_rsp.ar_ready, 0);
    mst_rsp.r_valid = 1'b1;
    mst_rsp.r.id    = 2'd0;
    mst_rsp.r.last  = 1'b0;
    #1;
    chk("reuse_r_nonlast_id", slv_rsp.r.id, 6'h10);
    tick;
    mst_rsp.r.last = 1'b1;
    #1;
    chk("reuse_nonlast_not_counted", slv_rsp.ar_ready, 0);
    tick;
    mst_rsp.r_valid = 1'b0;
    #1;
    chk("reuse_fifth_ready", slv_rsp.ar_ready, 1);
    chk("reuse_fifth_id", mst_req.ar.id, 0);
    tick;
    slv_req.ar_valid = 1'b0;
    mst_rsp.r_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("reuse_drain_r_id", slv_rsp.r.id, 6'h10);
      tick;
    end
    mst_rsp.r_valid = 1'b0;

    // HOLD stability: slot 1 stays locked while both slots drain
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 6'h01;
    tick;
    slv_req.ar.id    = 6'h07;
    tick;
    mst_rsp.ar_ready = 1'b0;
    #1;
    chk("hold_initial_id", mst_req.ar.id, 1);
    chk("hold_valid", mst_req.ar_valid, 1);
    tick;
    mst_rsp.r_valid = 1'b1;
    mst_rsp.r.id    = 2'd0;
    #1;
    chk("hold_r0_id", slv_rsp.r.id, 6'h01);
    chk("hold_id_c1", mst_req.ar.id, 1);
    tick;
    mst_rsp.r.id = 2'd1;
    #1;
    chk("hold_r1_id", slv_rsp.r.id, 6'h07);
    chk("hold_id_c2", mst_req.ar.id, 1);
    tick;
    mst_rsp.r_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("hold_id_after_drain", mst_req.ar.id, 1);
      chk("hold_valid_after_drain", mst_req.ar_valid, 1);
      tick;
    end
    mst_rsp.ar_ready = 1'b1;
    #1;
    chk("hold_hs_id", mst_req.ar.id, 1);
    chk("hold_hs_ready", slv_rsp.ar_ready, 1);
    tick;
    slv_req.ar_valid = 1'b0;
    mst_rsp.r_valid  = 1'b1;
    mst_rsp.r.id     = 2'd1;
    #1;
    chk("hold_release_id", slv_rsp.r.id, 6'h07);
    tick;
    mst_rsp.r_valid = 1'b0;

    // 8-beat burst restore
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 6'h3F;
    slv_req.ar.len   = 8'd7;
    #1;
    chk("burst_ar_id", mst_req.ar.id, 0);
    chk("burst_ar_len", mst_req.ar.len, 7);
    tick;
    slv_req.ar_valid = 1'b0;
    slv_req.ar.len   = 8'd0;
    mst_rsp.r_valid  = 1'b1;
    mst_rsp.r.id     = 2'd0;
    for (int b = 0; b < 8; b++) begin
      mst_rsp.r.last = (b == 7);
      mst_rsp.r.data = 64'hA0 + 64'(b);
      #1;
      chk("burst_r_id", slv_rsp.r.id, 6'h3F);
      chk("burst_r_data", slv_rsp.r.data, 64'hA0 + 64'(b));
      tick;
    end
    mst_rsp.r_valid  = 1'b0;
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 6'h15;
    #1;
    chk("burst_slot_freed", mst_req.ar.id, 0);
    tick;
    slv_req.ar_valid = 1'b0;
    mst_rsp.r_valid  = 1'b1;
    #1;
    chk("burst_next_r_id", slv_rsp.r.id, 6'h15);
    tick;
    mst_rsp.r_valid = 1'b0;

    // concurrent read/write with same wide ID, plus same-cycle alloc/release
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 6'h11;
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 6'h11;
    #1;
    chk("conc_aw_id", mst_req.aw.id, 0);
    chk("conc_ar_id", mst_req.ar.id, 0);
    tick;
    slv_req.ar_valid = 1'b0;
    mst_rsp.b_valid  = 1'b1;
    mst_rsp.b.id     = 2'd0;
    #1;
    chk("conc_realloc_id", mst_req.aw.id, 0);
    chk("conc_b_id", slv_rsp.b.id, 6'h11);
    tick;
    slv_req.aw_valid = 1'b0;
    mst_rsp.r_valid  = 1'b1;
    mst_rsp.r.id     = 2'd0;
    #1;
    chk("conc_b2_id", slv_rsp.b.id, 6'h11);
    chk("conc_r_id", slv_rsp.r.id, 6'h11);
    chk("conc_r_user_zero", slv_rsp.r.user, 0);
    tick;
    mst_rsp.b_valid  = 1'b0;
    mst_rsp.r_valid  = 1'b0;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 6'h12;
    #1;
    chk("conc_next_aw_id", mst_req.aw.id, 0);
    tick;
    slv_req.aw_valid = 1'b0;
    mst_rsp.b_valid  = 1'b1;
    #1;
    chk("conc_next_b_id", slv_rsp.b.id, 6'h12);
    tick;
    mst_rsp.b_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_axi_id_remap.md
# dram_axi_id_remap

AXI4 ID remapper placed between the DRAM-side spill register and the MIG slave port, in the DRAM AXI clock domain. It replaces the single-register ID truncation with per-direction remap tables, which makes multiple outstanding transactions with differing wide IDs legal. It compresses wide upstream IDs into the MIG's narrow ID space, restores the wide ID on B/R responses, and keeps AXI same-ID ordering. When no narrow ID is available, it back-pressures AW/AR.

## Interface
- SlvIdWidth, 6, upstream (wide) ID width
- MstIdWidth, 2, MIG ID width; table depth NumSlots = 2**MstIdWidth
- MaxTxnsPerId, 4, max outstanding transactions per slot (counter saturates here)
- slv_req_t / slv_rsp_t, logic, DRAM-width AXI req/resp with wide ID
- mst_req_t / mst_rsp_t, logic, same AXI channels with MstIdWidth ID
- clk_i  in  1  DRAM AXI clock (single clock domain)
- rst_ni  in  1  asynchronous, active-low reset
- slv_req_i  in  slv_req_t  upstream request
- slv_rsp_o  out  slv_rsp_t  upstream response, B/R IDs restored
- mst_req_o  out  mst_req_t  request to MIG, AW/AR IDs remapped
- mst_rsp_i  in  mst_rsp_t  MIG response

## Operation
- Two independent tables, write (AW/B) and read (AR/R). Each has NumSlots entries {valid, wide_id[SlvIdWidth], cnt[$clog2(MaxTxnsPerId+1)]}.
- Slot selection for an AW/AR with wide ID X:
  - If a valid slot holds X and cnt < MaxTxnsPerId, use that slot.
  - If a valid slot holds X and cnt == MaxTxnsPerId, stall.
  - If no slot holds X and a free slot exists, allocate the lowest-index free slot.
  - Otherwise stall.
- Reusing the slot that already holds X keeps same-ID ordering, because the MIG orders same-ID transactions.
- Forwarding: mst aw.id = slot index; all other AW/AR fields are passed unchanged. mst aw_valid = slv aw_valid && slot_ok. slv aw_ready = mst aw_ready && slot_ok. AR uses the same rules.
- On an AW handshake, the selected slot gets valid=1, wide_id=X, cnt+=1.
- Write release: on B handshake, slv b.id = table[b.id].wide_id and cnt-=1. The slot frees (valid=0) when cnt reaches 0.
- Read release: on R handshake with last=1, cnt-=1. Non-last R beats are not counted. R is ID-restored on every beat.
- W, B, R payloads and all handshakes other than the gated AW/AR valid/ready pass through combinationally.
- Stability lock, per channel, FSM IDLE/HOLD:
  - IDLE -> HOLD when mst valid && !mst ready. The selected slot index is latched into sel_q.
  - In HOLD, the output ID comes from sel_q. The slot in sel_q is never freed, even if cnt reaches 0.
  - HOLD -> IDLE on handshake.
- User fields: b.user/r.user are driven to 0.
- Response for an invalid slot (protocol error): the wide ID output is table content (stale). A simulation assertion fires. Tables are not modified.

## Timing
- Zero-cycle latency on every channel, with no added registers in the datapath. Only table state, sel_q and the FSM are registered.
- Table updates take effect in the cycle after the handshake. A slot freed in cycle N can be allocated in cycle N+1 at the earliest.
- Simultaneous allocate and release on the same slot in one cycle gives a net cnt change of 0. Valid stays 1.
- Simultaneous release reaching 0 and reuse-match of X in the same cycle: the match wins and the slot stays valid with cnt=1.
- Counter cannot overflow: the stall at cnt == MaxTxnsPerId guarantees it. Underflow is impossible for legal traffic.
- Reset state, asynchronous on rst_ni=0:
  - All valid=0, cnt=0, FSMs IDLE, sel_q=0.
  - Outputs: mst aw_valid/ar_valid/w_valid=0, slv aw_ready/ar_ready=0, and the remaining outputs mirror the (reset) inputs.
- Reset mid-transaction drops all tracking. The upstream spill and the MIG are reset in the same domain.

## Structure
- Package dram_axi_id_remap_pkg: slot entry struct type; functions for counter width and NumSlots.
- Sub-module dram_axi_id_table: one table plus the IDLE/HOLD lock. Instantiated twice (write, read). Ports: req valid/ready/id in, slot/ok out, release valid/slot in, wide_id out.
- Top level wires the channels and the ID substitution.

## Test plan
- Reset: hold rst_ni=0, drive aw_valid=1 -> aw_ready=0 and mst aw_valid=0. After release, AW with id 0x2A -> mst aw.id=0, and B returns slv b.id=0x2A.
- Slot exhaustion (write): AW ids 0x01, 0x02, 0x03, 0x04 -> mst ids 0,1,2,3. AW 0x05 stalls. After B for mst id 1, 0x05 is issued with mst id 1 one cycle later.
- Same-ID reuse: four AR with id 0x10 -> all use mst id 0 with cnt=4. A fifth stalls. The first R last=1 -> the fifth is accepted the next cycle.
- HOLD stability: AR 0x07 with mst ar_ready=0 for 5 cycles while that slot's last outstanding R completes -> ar.id stays constant and the slot stays valid until the handshake.
- Bursts: AR len=7 id 0x3F -> all 8 R beats carry r.id=0x3F. The slot frees only after the beat with last=1.
- Concurrent read/write: interleaved AW 0x11 and AR 0x11 -> both get mst id 0 in independent tables, and B/R are restored to 0x11.
